// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core pipeline: ALU op codes, default widths
// and the control half of the ID/EX stage register.
package mips_pkg;

    localparam int DW_DEF = 32;
    localparam int RW_DEF = 5;
    localparam int CTL_W  = 4;

    localparam logic [CTL_W-1:0] ALU_ADD = 4'd0;
    localparam logic [CTL_W-1:0] ALU_SUB = 4'd1;
    localparam logic [CTL_W-1:0] ALU_AND = 4'd2;
    localparam logic [CTL_W-1:0] ALU_NOR = 4'd3;
    localparam logic [CTL_W-1:0] ALU_OR  = 4'd4;
    localparam logic [CTL_W-1:0] ALU_SLT = 4'd5;
    localparam logic [CTL_W-1:0] ALU_XOR = 4'd6;

    // Width-independent part of the stage register; the DW/RW sized data
    // fields live next to it in the stage so the parameters stay overridable.
    typedef struct packed {
        logic             valid;
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
        logic             alu_src;
        logic [CTL_W-1:0] ctl;
    } id_ex_t;

    function automatic id_ex_t id_ex_bubble();
        id_ex_t t;
        t     = '0;
        t.ctl = ALU_ADD;
        return t;
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// One EX operand's forwarding select: EX/MEM beats MEM/WB beats the
// registered register-file value; register 0 is never forwarded.
module fwd_mux #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic [RW-1:0] src_idx,
    input  logic [DW-1:0] reg_data,
    input  logic          exmem_reg_write,
    input  logic [RW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_reg_write,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_result,
    output logic [DW-1:0] fwd_data
);

    logic hit_exmem;
    logic hit_memwb;

    assign hit_exmem = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == src_idx);
    assign hit_memwb = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == src_idx);

    always_comb begin
        fwd_data = reg_data;
        if (hit_exmem) begin
            fwd_data = exmem_result;
        end else if (hit_memwb) begin
            fwd_data = memwb_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side operand forwarding and load-use
// bubble insertion.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          hold,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs_idx,
    input  logic [RW-1:0] id_rt_idx,
    input  logic [RW-1:0] id_rd_idx,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic          id_alu_src,
    input  logic [3:0]    id_alu_ctl,
    input  logic          id_reg_dst,
    input  logic          id_reg_write,
    input  logic          id_mem_read,
    input  logic          id_mem_write,
    input  logic          exmem_reg_write,
    input  logic [RW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_reg_write,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_result,
    output logic          load_use_stall,
    output logic          ex_valid,
    output logic [3:0]    ctl,
    output logic [DW-1:0] a,
    output logic [DW-1:0] b,
    output logic [DW-1:0] ex_store_data,
    output logic [RW-1:0] ex_dest,
    output logic          ex_reg_write,
    output logic          ex_mem_read,
    output logic          ex_mem_write
);

    id_ex_t        ex_q;
    logic [RW-1:0] rs_idx_q;
    logic [RW-1:0] rt_idx_q;
    logic [RW-1:0] dest_q;
    logic [DW-1:0] rs_data_q;
    logic [DW-1:0] rt_data_q;
    logic [DW-1:0] imm_q;

    logic          load_bubble;
    logic          dest_hits_src;
    logic [DW-1:0] fwd_rs;
    logic [DW-1:0] fwd_rt;

    // A load in EX whose destination ID is about to read cannot be forwarded
    // in time; the ID instruction must wait one cycle behind a bubble.
    assign dest_hits_src  = (dest_q == id_rs_idx) || (dest_q == id_rt_idx);
    assign load_use_stall = ex_q.valid && ex_q.mem_read && (dest_q != '0)
                            && id_valid && dest_hits_src;

    // flush outranks hold; a stall only turns into a bubble when not held.
    assign load_bubble = rst || flush || (!hold && load_use_stall);

    always_ff @(posedge clk) begin
        if (load_bubble) begin
            ex_q      <= id_ex_bubble();
            rs_idx_q  <= '0;
            rt_idx_q  <= '0;
            dest_q    <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
        end else if (!hold) begin
            ex_q.valid     <= id_valid;
            ex_q.reg_write <= id_reg_write & id_valid;
            ex_q.mem_read  <= id_mem_read  & id_valid;
            ex_q.mem_write <= id_mem_write & id_valid;
            ex_q.alu_src   <= id_alu_src;
            ex_q.ctl       <= id_alu_ctl;
            rs_idx_q       <= id_rs_idx;
            rt_idx_q       <= id_rt_idx;
            dest_q         <= id_reg_dst ? id_rd_idx : id_rt_idx;
            rs_data_q      <= id_rs_data;
            rt_data_q      <= id_rt_data;
            imm_q          <= id_imm;
        end
    end

    // Forwarding runs off the registered indices every cycle, held or not.
    fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
        .src_idx         (rs_idx_q),
        .reg_data        (rs_data_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .fwd_data        (fwd_rs)
    );

    fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
        .src_idx         (rt_idx_q),
        .reg_data        (rt_data_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .fwd_data        (fwd_rt)
    );

    assign ctl           = ex_q.ctl;
    assign a             = fwd_rs;
    assign b             = ex_q.alu_src ? imm_q : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign ex_dest       = dest_q;
    assign ex_valid      = ex_q.valid;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table plus hand-written sequences
// for reset, load-use, hold/flush and a randomised forwarding sweep.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst, flush, hold;
    logic        id_valid;
    logic [4:0]  id_rs_idx, id_rt_idx, id_rd_idx;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write;
    logic [3:0]  id_alu_ctl;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic        load_use_stall, ex_valid;
    logic [3:0]  ctl;
    logic [31:0] a, b, ex_store_data;
    logic [4:0]  ex_dest;
    logic        ex_reg_write, ex_mem_read, ex_mem_write;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .hold(hold),
        .id_valid(id_valid), .id_rs_idx(id_rs_idx), .id_rt_idx(id_rt_idx),
        .id_rd_idx(id_rd_idx), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_alu_src(id_alu_src), .id_alu_ctl(id_alu_ctl),
        .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
        .exmem_result(exmem_result), .memwb_reg_write(memwb_reg_write),
        .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .load_use_stall(load_use_stall), .ex_valid(ex_valid), .ctl(ctl),
        .a(a), .b(b), .ex_store_data(ex_store_data), .ex_dest(ex_dest),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write)
    );

    typedef struct {
        logic        valid;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rs_d, rt_d, imm;
        logic        alu_src, reg_dst, rw;
        logic [3:0]  alu_ctl;
        logic        exm_we;
        logic [4:0]  exm_rd;
        logic [31:0] exm_res;
        logic        mwb_we;
        logic [4:0]  mwb_rd;
        logic [31:0] mwb_res;
        logic [31:0] exp_a, exp_b, exp_st;
        logic [4:0]  exp_dest;
        logic        exp_rw;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        flush = 0; hold = 0;
        id_valid = 0; id_rs_idx = 0; id_rt_idx = 0; id_rd_idx = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        id_alu_src = 0; id_reg_dst = 0; id_alu_ctl = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] rs_d,
                          input logic [31:0] rt_d, input logic [31:0] imm,
                          input logic alu_src, input logic reg_dst,
                          input logic [3:0] c, input logic rw, input logic mr);
        id_valid = v; id_rs_idx = rs; id_rt_idx = rt; id_rd_idx = rd;
        id_rs_data = rs_d; id_rt_data = rt_d; id_imm = imm;
        id_alu_src = alu_src; id_reg_dst = reg_dst; id_alu_ctl = c;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = 1'b0;
    endtask

    function automatic vec_t mk(
        logic v, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
        logic [31:0] rs_d, logic [31:0] rt_d, logic [31:0] imm,
        logic alu_src, logic reg_dst, logic [3:0] c, logic rw,
        logic ewe, logic [4:0] erd, logic [31:0] eres,
        logic mwe, logic [4:0] mrd, logic [31:0] mres,
        logic [31:0] ea, logic [31:0] eb, logic [31:0] est, logic [4:0] ed, logic erw);
        vec_t t;
        t.valid = v; t.rs = rs; t.rt = rt; t.rd = rd;
        t.rs_d = rs_d; t.rt_d = rt_d; t.imm = imm;
        t.alu_src = alu_src; t.reg_dst = reg_dst; t.alu_ctl = c; t.rw = rw;
        t.exm_we = ewe; t.exm_rd = erd; t.exm_res = eres;
        t.mwb_we = mwe; t.mwb_rd = mrd; t.mwb_res = mres;
        t.exp_a = ea; t.exp_b = eb; t.exp_st = est; t.exp_dest = ed; t.exp_rw = erw;
        return t;
    endfunction

    // Independent reference for one forwarded operand.
    function automatic logic [31:0] ref_fwd(logic [4:0] idx, logic [31:0] d);
        if (idx == 5'd0) return d;
        if (exmem_reg_write && exmem_rd == idx) return exmem_result;
        if (memwb_reg_write && memwb_rd == idx) return memwb_result;
        return d;
    endfunction

    initial begin
        logic [4:0]  r_rs, r_rt, r_rd;
        logic [31:0] r_rsd, r_rtd, r_imm, e_a, e_b, e_st;
        logic        r_src, r_dst, r_v;
        logic [3:0]  r_ctl;

        //                v  rs  rt  rd  rs_d        rt_d   imm          src dst ctl rw  ewe erd  eres        mwe mrd  mres        exp_a       exp_b        exp_st  dest rw
        vecs[0] = mk(1, 3,  4,  9,  32'd10,     32'd20, 32'd0,       0, 1, 1, 1, 0, 0,  32'h0,       0, 0,  32'h0,       32'd10,     32'd20,       32'd20, 9,  1);
        vecs[1] = mk(1, 3,  4,  9,  32'd10,     32'd20, 32'hFFFFFFFE,1, 0, 2, 1, 0, 0,  32'h0,       0, 0,  32'h0,       32'd10,     32'hFFFFFFFE, 32'd20, 4,  1);
        vecs[2] = mk(1, 5,  6,  0,  32'hAA,     32'hBB, 32'd0,       0, 0, 0, 1, 1, 5,  32'h111,     1, 5,  32'h222,     32'h111,    32'hBB,       32'hBB, 6,  1);
        vecs[3] = mk(1, 5,  6,  0,  32'hAA,     32'hBB, 32'd0,       0, 0, 0, 1, 0, 5,  32'h111,     1, 5,  32'h222,     32'h222,    32'hBB,       32'hBB, 6,  1);
        vecs[4] = mk(1, 0,  0,  12, 32'h33,     32'h44, 32'd0,       0, 1, 3, 1, 1, 0,  32'h111,     1, 0,  32'h222,     32'h33,     32'h44,       32'h44, 12, 1);
        vecs[5] = mk(1, 8,  9,  0,  32'd1,      32'd2,  32'd7,       1, 0, 4, 0, 1, 9,  32'h999,     1, 8,  32'h888,     32'h888,    32'd7,        32'h999, 9, 0);
        vecs[6] = mk(0, 1,  2,  31, 32'd5,      32'd6,  32'd0,       0, 1, 6, 1, 1, 3,  32'hDEAD,    0, 1,  32'hBEEF,    32'd5,      32'd6,        32'd6,  31, 0);
        vecs[7] = mk(1, 10, 11, 0,  32'h100,    32'h200,32'd0,       0, 0, 5, 0, 1, 10, 32'hA0A0,    1, 11, 32'hB0B0,    32'hA0A0,   32'hB0B0,     32'hB0B0, 11, 0);

        // Reset with a live instruction sitting in ID.
        clear_inputs();
        rst = 1;
        set_id(1, 3, 4, 5, 32'd10, 32'd20, 32'd1, 0, 1, 4'd2, 1, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_ctl", {28'd0, ctl}, 32'd0);
        chk("rst_a", a, 32'd0);
        chk("rst_b", b, 32'd0);
        chk("rst_reg_write", {31'd0, ex_reg_write}, 32'd0);
        chk("rst_stall", {31'd0, load_use_stall}, 32'd0);
        rst = 0;
        clear_inputs();

        // Table: capture, immediate select and forwarding priority.
        for (int i = 0; i < 8; i++) begin
            set_id(vecs[i].valid, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].rs_d,
                   vecs[i].rt_d, vecs[i].imm, vecs[i].alu_src, vecs[i].reg_dst,
                   vecs[i].alu_ctl, vecs[i].rw, 1'b0);
            @(posedge clk);
            #1;
            exmem_reg_write = vecs[i].exm_we; exmem_rd = vecs[i].exm_rd;
            exmem_result = vecs[i].exm_res;
            memwb_reg_write = vecs[i].mwb_we; memwb_rd = vecs[i].mwb_rd;
            memwb_result = vecs[i].mwb_res;
            #1;
            chk($sformatf("v%0d_a", i), a, vecs[i].exp_a);
            chk($sformatf("v%0d_b", i), b, vecs[i].exp_b);
            chk($sformatf("v%0d_store", i), ex_store_data, vecs[i].exp_st);
            chk($sformatf("v%0d_dest", i), {27'd0, ex_dest}, {27'd0, vecs[i].exp_dest});
            chk($sformatf("v%0d_ctl", i), {28'd0, ctl}, {28'd0, vecs[i].alu_ctl});
            chk($sformatf("v%0d_valid", i), {31'd0, ex_valid}, {31'd0, vecs[i].valid});
            chk($sformatf("v%0d_reg_write", i), {31'd0, ex_reg_write}, {31'd0, vecs[i].exp_rw});
        end
        clear_inputs();

        // Load-use: load to r7 in EX, dependent instruction in ID.
        set_id(1, 1, 7, 0, 32'd0, 32'd0, 32'd4, 1, 0, 4'd0, 1, 1);
        @(posedge clk);
        #1;
        chk("lu_ex_mem_read", {31'd0, ex_mem_read}, 32'd1);
        set_id(1, 2, 7, 3, 32'h50, 32'h60, 32'd0, 0, 1, 4'd1, 1, 0);
        #1;
        chk("lu_stall_rt", {31'd0, load_use_stall}, 32'd1);
        id_valid = 0;
        #1;
        chk("lu_stall_idle_id", {31'd0, load_use_stall}, 32'd0);
        id_valid = 1; id_rs_idx = 7; id_rt_idx = 2; id_rt_data = 32'h60;
        #1;
        chk("lu_stall_rs", {31'd0, load_use_stall}, 32'd1);
        id_rs_idx = 2; id_rt_idx = 7;
        @(posedge clk);
        #1;
        chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
        chk("lu_bubble_mem_read", {31'd0, ex_mem_read}, 32'd0);
        chk("lu_bubble_ctl", {28'd0, ctl}, 32'd0);
        chk("lu_stall_drop", {31'd0, load_use_stall}, 32'd0);
        @(posedge clk);
        #1;
        chk("lu_release_valid", {31'd0, ex_valid}, 32'd1);
        chk("lu_release_a", a, 32'h50);
        chk("lu_release_b", b, 32'h60);
        // A load writing r0 never stalls.
        set_id(1, 1, 0, 0, 32'd0, 32'd0, 32'd0, 1, 0, 4'd0, 1, 1);
        @(posedge clk);
        #1;
        set_id(1, 0, 0, 0, 32'd1, 32'd2, 32'd0, 0, 0, 4'd0, 0, 0);
        #1;
        chk("lu_r0_no_stall", {31'd0, load_use_stall}, 32'd0);
        // Flush wins over a pending stall.
        set_id(1, 1, 7, 0, 32'd0, 32'd0, 32'd4, 1, 0, 4'd0, 1, 1);
        @(posedge clk);
        #1;
        set_id(1, 7, 1, 0, 32'd0, 32'd0, 32'd0, 0, 0, 4'd3, 1, 0);
        flush = 1;
        @(posedge clk);
        #1;
        chk("lu_flush_valid", {31'd0, ex_valid}, 32'd0);
        chk("lu_flush_dest", {27'd0, ex_dest}, 32'd0);
        clear_inputs();

        // Hold: stage freezes, forwarding keeps tracking.
        set_id(1, 2, 6, 0, 32'h30, 32'h40, 32'd0, 0, 0, 4'd4, 1, 0);
        exmem_reg_write = 1; exmem_rd = 2; exmem_result = 32'h5;
        @(posedge clk);
        #1;
        chk("hold_pre_a", a, 32'h5);
        hold = 1;
        set_id(1, 9, 10, 0, 32'h77, 32'h88, 32'd0, 1, 0, 4'd2, 0, 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("hold%0d_ctl", k), {28'd0, ctl}, 32'd4);
            chk($sformatf("hold%0d_b", k), b, 32'h40);
            chk($sformatf("hold%0d_a", k), a, (k == 0) ? 32'h5 : 32'h9);
            exmem_result = 32'h9;
            #1;
            chk($sformatf("hold%0d_a_fwd", k), a, 32'h9);
        end
        flush = 1;
        @(posedge clk);
        #1;
        chk("hold_flush_valid", {31'd0, ex_valid}, 32'd0);
        chk("hold_flush_ctl", {28'd0, ctl}, 32'd0);
        flush = 0; hold = 0;
        set_id(1, 2, 6, 0, 32'h30, 32'h40, 32'd0, 0, 0, 4'd5, 1, 0);
        @(posedge clk);
        #1;
        hold = 1; rst = 1;
        @(posedge clk);
        #1;
        chk("hold_rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("hold_rst_a", a, 32'd0);
        rst = 0;
        clear_inputs();

        // Randomised forwarding sweep against the reference model.
        for (int n = 0; n < 50; n++) begin
            r_v = 1'($urandom_range(0, 1));
            r_rs = 5'($urandom_range(0, 7)); r_rt = 5'($urandom_range(0, 7));
            r_rd = 5'($urandom_range(0, 31));
            r_rsd = $urandom; r_rtd = $urandom; r_imm = $urandom;
            r_src = 1'($urandom_range(0, 1)); r_dst = 1'($urandom_range(0, 1));
            r_ctl = 4'($urandom_range(0, 6));
            set_id(r_v, r_rs, r_rt, r_rd, r_rsd, r_rtd, r_imm, r_src, r_dst, r_ctl, 1, 0);
            @(posedge clk);
            #1;
            exmem_reg_write = 1'($urandom_range(0, 1)); exmem_rd = 5'($urandom_range(0, 7));
            exmem_result = $urandom;
            memwb_reg_write = 1'($urandom_range(0, 1)); memwb_rd = 5'($urandom_range(0, 7));
            memwb_result = $urandom;
            #1;
            e_a = ref_fwd(r_rs, r_rsd);
            e_st = ref_fwd(r_rt, r_rtd);
            e_b = r_src ? r_imm : e_st;
            chk($sformatf("rnd%0d_a", n), a, e_a);
            chk($sformatf("rnd%0d_b", n), b, e_b);
            chk($sformatf("rnd%0d_store", n), ex_store_data, e_st);
            chk($sformatf("rnd%0d_ctl", n), {28'd0, ctl}, {28'd0, r_ctl});
            chk($sformatf("rnd%0d_dest", n), {27'd0, ex_dest}, {27'd0, (r_dst ? r_rd : r_rt)});
            chk($sformatf("rnd%0d_valid", n), {31'd0, ex_valid}, {31'd0, r_v});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and EX-side operand forwarding for the MIPS core.
- Captures decoded fields from ID and resolves RAW hazards against EX/MEM and MEM/WB results.
- Drives the ALU's ctl, a and b ports, plus store data and destination info for the next stage.
- Detects load-use hazards and inserts a one-cycle bubble.

Parameters:
- DW, 32, datapath width
- RW, 5, register index width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  kill the instruction entering EX (branch/jump redirect)
- hold  in  1  freeze stage contents (downstream wait)
- id_valid  in  1  ID holds a real instruction
- id_rs_idx, id_rt_idx, id_rd_idx  in  RW each  source and destination register indices
- id_rs_data, id_rt_data  in  DW each  register-file read data
- id_imm  in  DW  sign/zero-extended immediate
- id_alu_src  in  1  1 = b takes the immediate
- id_alu_ctl  in  4  ALU op code
- id_reg_dst  in  1  1 = destination is rd, 0 = rt
- id_reg_write, id_mem_read, id_mem_write  in  1 each  control bits
- exmem_reg_write  in  1  EX/MEM write enable
- exmem_rd  in  RW  EX/MEM destination index
- exmem_result  in  DW  EX/MEM result
- memwb_reg_write  in  1  MEM/WB write enable
- memwb_rd  in  RW  MEM/WB destination index
- memwb_result  in  DW  MEM/WB result
- load_use_stall  out  1  request ID/IF hold (combinational)
- ex_valid  out  1  EX holds a real instruction
- ctl  out  4  to ALU
- a, b  out  DW each  forwarded ALU operands
- ex_store_data  out  DW  forwarded rt value
- ex_dest  out  RW  selected destination index
- ex_reg_write, ex_mem_read, ex_mem_write  out  1 each  registered control bits

Behaviour:
- Register update priority at each posedge clk: rst > flush > hold > load_use_stall > capture.
- Reset or flush:
  - ex_valid, ex_reg_write, ex_mem_read, ex_mem_write = 0.
  - ctl = ALU_ADD (0); stored rs/rt data, imm, indices and ex_dest = 0.
- hold: all stage registers keep their values.
- load_use_stall (hold low): load a bubble with the same values as reset. The upstream stages must hold ID.
- Otherwise capture all id_* fields.
  - ex_dest = id_reg_dst ? id_rd_idx : id_rt_idx.
  - Control bits are ANDed with id_valid.
- Latency: one cycle from ID inputs to ctl/a/b.
- load_use_stall = ex_valid & ex_mem_read & (ex_dest != 0) & id_valid & (ex_dest == id_rs_idx | ex_dest == id_rt_idx). It is combinational and does not depend on hold.
- Forwarding is combinational on the registered rs/rt indices. For each source s in {rs, rt}:
  - if exmem_reg_write & exmem_rd != 0 & exmem_rd == s_idx: use exmem_result;
  - else if memwb_reg_write & memwb_rd != 0 & memwb_rd == s_idx: use memwb_result;
  - else use the registered s_data.
- Register 0 is never forwarded; a zero index always yields the registered data.
- Forwarding is re-evaluated every cycle, including while hold is high, so a held instruction sees the latest producers.
- Operand selection:
  - a = forwarded rs.
  - b = alu_src ? imm : forwarded rt.
  - ex_store_data = forwarded rt, regardless of alu_src.
- All data widths are DW with no extension inside the block; the immediate arrives already extended.
- ctl passes through unchanged.
- Simultaneous events:
  - flush with hold: flush wins.
  - flush with load_use_stall: flush wins; the bubble is identical anyway.
  - rst mid-hold: the stage clears on that edge.

Decomposition:
- Package mips_pkg holds:
  - the ALU op constants: ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_NOR=3, ALU_OR=4, ALU_SLT=5, ALU_XOR=6;
  - the DW/RW defaults;
  - a packed id_ex_t struct for the stage register.
- One sub-module, fwd_mux: one operand's priority compare and select. It is instantiated twice (rs, rt).

Test Plan:
- Reset: rst=1 for 2 cycles with id_valid=1 → ex_valid=0, ctl=0, a=b=0, ex_reg_write=0, load_use_stall=0.
- Plain capture: rs=3/data 10, rt=4/data 20, alu_src=0, ctl=1 → next cycle a=10, b=20, ctl=1. With alu_src=1 and imm=0xFFFFFFFE → b=0xFFFFFFFE, ex_store_data=20.
- Forwarding priority with rs=5 in EX:
  - exmem_rd=5, exmem_result=0x111 and memwb_rd=5, memwb_result=0x222 → a=0x111;
  - drop exmem_reg_write → a=0x222;
  - set rs=0 with both producers targeting rd=0 → a = registered data.
- Load-use: EX holds mem_read with ex_dest=7, ID has rt=7 → load_use_stall=1. The next edge loads a bubble (ex_valid=0) and load_use_stall drops.
- Hold/flush:
  - hold=1 for 3 cycles → ctl/a/b stable except that a forwarding change (exmem_result 0x5→0x9) appears on a;
  - flush=1 with hold=1 → ex_valid=0 next cycle.
- Randomised: 50 instructions with random ctl in 0..6 and random producers → a/b match a reference model.
